cordic_output_stage: RTL and testbench

Sits directly downstream of the last cordic_stage in the rotation pipeline. It consumes the final x/y/z/valid plus the 2-bit quadrant tag that travels alongside the pipeline. It applies the quadrant correction with saturation and registers the corrected cos/sin pair. It then buffers results in a small FIFO behind a ready/valid interface toward the audio consumer, because the CORDIC pipeline itself has no backpressure.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_output_stage_if.sv | 10 +
 rtl/cordic_sample_fifo.sv | 51 +++++
 rtl/cordic_output_stage.sv | 80 ++++++++
 tb/tb_cordic_output_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and helpers for the CORDIC output stage
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  typedef struct packed {
    logic signed [CORDIC_WIDTH-1:0] cos;
    logic signed [CORDIC_WIDTH-1:0] sin;
  } sample_t;

  // The most negative code has no positive twin, so it clamps to the largest positive code.
  function automatic logic signed [CORDIC_WIDTH-1:0] sat_neg(input logic signed [CORDIC_WIDTH-1:0] v);
    if (v == {1'b1, {(CORDIC_WIDTH-1){1'b0}}})
      return {1'b0, {(CORDIC_WIDTH-1){1'b1}}};
    return -v;
  endfunction

endpackage

// File: rtl/cordic_output_stage_if.sv
// rtl/cordic_output_stage_if.sv - ready/valid sample stream toward the audio consumer
interface cordic_output_stage_if #(parameter int WIDTH = cordic_pkg::CORDIC_WIDTH);
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output cos_out, sin_out, out_valid, input out_ready);
  modport slave  (input cos_out, sin_out, out_valid, output out_ready);
endinterface

// File: rtl/cordic_sample_fifo.sv
// rtl/cordic_sample_fifo.sv - synchronous FIFO of cos/sin samples, registered-head (no fall-through)
module cordic_sample_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  sample_t                  din,
  input  logic                     pop,
  output sample_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  sample_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/cordic_output_stage.sv
// rtl/cordic_output_stage.sv - quadrant correction with saturation, then buffered ready/valid output
module cordic_output_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  input  logic signed [WIDTH-1:0]   z_in,
  input  logic [1:0]                quad_in,
  input  logic                      valid_in,
  cordic_output_stage_if.master     out_if,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [$clog2(DEPTH):0]    level
);

  sample_t corr;
  sample_t s1_sample;
  sample_t head;
  logic    s1_valid;
  logic    full;
  logic    empty;
  logic    pop;
  logic    drop;
  logic    unused_z;

  // The residual angle is carried by the pipeline but has no effect on the result.
  assign unused_z = ^z_in;

  always_comb begin
    corr = '0;
    case (quad_t'(quad_in))
      Q0: begin corr.cos = x_in;          corr.sin = y_in;          end
      Q1: begin corr.cos = sat_neg(y_in); corr.sin = x_in;          end
      Q2: begin corr.cos = sat_neg(x_in); corr.sin = sat_neg(y_in); end
      Q3: begin corr.cos = y_in;          corr.sin = sat_neg(x_in); end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sample <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) s1_sample <= corr;
    end
  end

  assign pop  = out_if.out_valid && out_if.out_ready;
  assign drop = s1_valid && full && !pop;

  cordic_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s1_valid),
    .din   (s1_sample),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_if.out_valid = !empty;
  assign out_if.cos_out   = head.cos;
  assign out_if.sin_out   = head.sin;

  // A drop in the same cycle as a clear keeps the flag set so the loss is never missed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_cordic_output_stage.sv
// tb/tb_cordic_output_stage.sv - self-checking bench for cordic_output_stage
module tb_cordic_output_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct { int x; int y; int q; int c; int s; } vec_t;
  typedef struct { int c; int s; } smp_t;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic signed [WIDTH-1:0] x_in = '0;
  logic signed [WIDTH-1:0] y_in = '0;
  logic signed [WIDTH-1:0] z_in = '0;
  logic [1:0]              quad_in = '0;
  logic                    valid_in = 1'b0;
  logic                    overflow;
  logic                    clear_overflow = 1'b0;
  logic [LW-1:0]           level;

  cordic_output_stage_if #(.WIDTH(WIDTH)) out_if ();

  cordic_output_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .x_in           (x_in),
    .y_in           (y_in),
    .z_in           (z_in),
    .quad_in        (quad_in),
    .valid_in       (valid_in),
    .out_if         (out_if),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .level          (level)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [8];
  smp_t fifo_q [$];
  smp_t m_s1;
  bit   m_s1_v;
  bit   m_ovf;

  task automatic check(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_seq(input int k);
    valid_in = 1'b1;
    x_in     = WIDTH'(k * 100 + 7);
    y_in     = WIDTH'(k);
    quad_in  = 2'd0;
    z_in     = WIDTH'($urandom);
  endtask

  function automatic int sneg(input int v);
    return (-v > 32767) ? 32767 : -v;
  endfunction

  function automatic smp_t ref_correct(input int x, input int y, input int q);
    smp_t r;
    case (q)
      0:       begin r.c = x;       r.s = y;       end
      1:       begin r.c = sneg(y); r.s = x;       end
      2:       begin r.c = sneg(x); r.s = sneg(y); end
      default: begin r.c = y;       r.s = sneg(x); end
    endcase
    return r;
  endfunction

  initial begin
    vecs[0] = '{16384,      0, 1,      0,  16384};
    vecs[1] = '{16384,      0, 0,  16384,      0};
    vecs[2] = '{ 1000,  -2000, 2,  -1000,   2000};
    vecs[3] = '{-32768,   100, 2,  32767,   -100};
    vecs[4] = '{-32768,   100, 3,    100,  32767};
    vecs[5] = '{-32768, -32768, 1, 32767, -32768};
    vecs[6] = '{  123, -32768, 3, -32768,   -123};
    vecs[7] = '{32767, -32768, 0,  32767, -32768};

    out_if.out_ready = 1'b0;
    repeat (3) tick();
    check("reset_out_valid", out_if.out_valid, 0);
    check("reset_level", level, 0);
    check("reset_cos", $signed(out_if.cos_out), 0);
    check("reset_sin", $signed(out_if.sin_out), 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      x_in     = WIDTH'(vecs[i].x);
      y_in     = WIDTH'(vecs[i].y);
      quad_in  = 2'(vecs[i].q);
      z_in     = WIDTH'($urandom);
      tick();
      valid_in = 1'b0;
      check("vec_lat1_valid", out_if.out_valid, 0);
      tick();
      check("vec_valid", out_if.out_valid, 1);
      check("vec_cos", $signed(out_if.cos_out), vecs[i].c);
      check("vec_sin", $signed(out_if.sin_out), vecs[i].s);
      check("vec_level1", level, 1);
      tick();
      check("vec_popped", out_if.out_valid, 0);
      check("vec_level0", level, 0);
    end

    // Six samples into a stalled consumer: four kept, two dropped.
    out_if.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin drive_seq(k); tick(); end
    valid_in = 1'b0;
    tick();
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1);
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_valid", out_if.out_valid, 1);
      check("ovf_drain_cos", $signed(out_if.cos_out), k * 100 + 7);
      tick();
    end
    check("ovf_drained", out_if.out_valid, 0);

    // Clear coinciding with a drop leaves the flag set; a lone clear drops it.
    out_if.out_ready = 1'b0;
    for (int k = 10; k < 14; k++) begin drive_seq(k); tick(); end
    valid_in = 1'b0;
    tick();
    drive_seq(14);
    tick();
    valid_in       = 1'b0;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr_drop_set_wins", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr_alone", overflow, 0);
    out_if.out_ready = 1'b1;
    repeat (4) tick();
    check("clr_drained", level, 0);

    // Full FIFO with a ready consumer and a continuous stream: no loss.
    out_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin drive_seq(k); tick(); end
    valid_in = 1'b0;
    tick();
    check("stream_full", level, DEPTH);
    drive_seq(4);
    tick();
    for (int i = 0; i < 8; i++) begin
      out_if.out_ready = 1'b1;
      drive_seq(5 + i);
      check("stream_valid", out_if.out_valid, 1);
      check("stream_cos", $signed(out_if.cos_out), i * 100 + 7);
      tick();
      check("stream_level", level, DEPTH);
      check("stream_no_ovf", overflow, 0);
    end
    valid_in = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("stream_tail_cos", $signed(out_if.cos_out), (8 + j) * 100 + 7);
      check("stream_tail_sin", $signed(out_if.sin_out), 8 + j);
      tick();
    end
    check("stream_empty", out_if.out_valid, 0);

    // Asynchronous reset mid-stream with level 3 and overflow set.
    out_if.out_ready = 1'b0;
    for (int k = 20; k < 25; k++) begin drive_seq(k); tick(); end
    valid_in = 1'b0;
    tick();
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    check("mid_level3", level, 3);
    check("mid_ovf_set", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", out_if.out_valid, 0);
    check("async_level", level, 0);
    check("async_overflow", overflow, 0);
    tick();
    reset = 1'b0;
    drive_seq(50);
    tick();
    valid_in = 1'b0;
    check("post_rst_lat1", out_if.out_valid, 0);
    tick();
    check("post_rst_valid", out_if.out_valid, 1);
    check("post_rst_cos", $signed(out_if.cos_out), 5007);
    out_if.out_ready = 1'b1;
    tick();
    check("post_rst_level0", level, 0);

    // Random traffic against a queue-level model.
    fifo_q.delete();
    m_s1_v = 1'b0;
    m_ovf  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int sz;
      bit m_pop;
      bit m_drop;
      check("rnd_valid", out_if.out_valid, (fifo_q.size() > 0) ? 1 : 0);
      if (fifo_q.size() > 0) begin
        check("rnd_cos", $signed(out_if.cos_out), fifo_q[0].c);
        check("rnd_sin", $signed(out_if.sin_out), fifo_q[0].s);
      end
      check("rnd_level", level, fifo_q.size());
      check("rnd_overflow", overflow, m_ovf);

      valid_in         = ($urandom_range(0, 3) != 0);
      out_if.out_ready = ($urandom_range(0, 1) == 1);
      clear_overflow   = ($urandom_range(0, 15) == 0);
      x_in    = ($urandom_range(0, 7) == 0) ? 16'sh8000 : WIDTH'($urandom);
      y_in    = ($urandom_range(0, 7) == 0) ? 16'sh8000 : WIDTH'($urandom);
      z_in    = WIDTH'($urandom);
      quad_in = 2'($urandom_range(0, 3));

      sz     = fifo_q.size();
      m_pop  = (sz > 0) && out_if.out_ready;
      if (m_pop) void'(fifo_q.pop_front());
      m_drop = 1'b0;
      if (m_s1_v) begin
        if (sz == DEPTH && !m_pop) m_drop = 1'b1;
        else fifo_q.push_back(m_s1);
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_s1_v = valid_in;
      if (valid_in) m_s1 = ref_correct(int'(x_in), int'(y_in), int'(quad_in));

      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
